// File: rtl/gf233_pp_accum_reduce_if.sv
// Partial-product input stream and reduced-result output bundle for gf233_pp_accum_reduce.
interface gf233_pp_accum_reduce_if #(
  parameter int unsigned DW = 15,
  parameter int unsigned M  = 233
);
  localparam int unsigned PW = 2 * DW - 1;

  logic          pp_valid;
  logic          pp_ready;
  logic [PW-1:0] pp_data;
  logic [3:0]    pp_i;
  logic [3:0]    pp_j;
  logic          pp_last;
  logic          res_valid;
  logic          res_ready;
  logic [M-1:0]  res_data;

  modport master (
    output pp_valid, pp_data, pp_i, pp_j, pp_last, res_ready,
    input  pp_ready, res_valid, res_data
  );

  modport slave (
    input  pp_valid, pp_data, pp_i, pp_j, pp_last, res_ready,
    output pp_ready, res_valid, res_data
  );
endinterface

// File: rtl/gf233_pp_accum_reduce.sv
// XOR-accumulates tagged 15x15 carry-less partial products and folds the sum mod x^233+x^74+1.
// Optional beat-count check compiled in with PP_COUNT_CHECK_EN.
module gf233_pp_accum_reduce #(
  parameter int unsigned DW  = 15,
  parameter int unsigned M   = 233,
  parameter int unsigned K   = 74,
  parameter int unsigned NPP = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  gf233_pp_accum_reduce_if.slave bus,
  output logic                   busy,
  output logic                   err
);
  localparam int unsigned AW = 32 * DW;
  localparam int unsigned SW = 9;

  localparam logic [1:0] ACC   = 2'd0;
  localparam logic [1:0] FOLD1 = 2'd1;
  localparam logic [1:0] FOLD2 = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [AW-1:0] pp_ext, h, fold;
  logic [SW-1:0] shamt;
  logic [M-1:0]  res_data_r, res_data_nxt;
  logic          res_valid_r, res_valid_nxt;
  logic          busy_nxt;
  logic          pp_hs, res_hs;

  assign bus.pp_ready  = (state == ACC);
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign pp_hs         = bus.pp_valid && (state == ACC);
  assign res_hs        = res_valid_r && bus.res_ready && (state == OUT);

  // Beat alignment and one trinomial fold of the high part onto the low part.
  always_comb begin
    shamt  = SW'(DW * (32'(bus.pp_i) + 32'(bus.pp_j)));
    pp_ext = AW'(bus.pp_data) << shamt;
    h      = AW'(acc[AW-1:M]);
    fold   = AW'(acc[M-1:0]) ^ h ^ (h << K);
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    res_data_nxt  = res_data_r;
    res_valid_nxt = res_valid_r;
    busy_nxt      = busy;
    case (state)
      ACC: begin
        if (pp_hs) begin
          acc_nxt  = acc ^ pp_ext;
          busy_nxt = 1'b1;
          if (bus.pp_last) state_nxt = FOLD1;
        end
      end
      FOLD1: begin
        acc_nxt   = fold;
        state_nxt = FOLD2;
      end
      FOLD2: begin
        acc_nxt       = fold;
        res_data_nxt  = fold[M-1:0];
        res_valid_nxt = 1'b1;
        state_nxt     = OUT;
      end
      OUT: begin
        if (res_hs) begin
          acc_nxt       = '0;
          res_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      res_data_r  <= '0;
      res_valid_r <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      res_data_r  <= res_data_nxt;
      res_valid_r <= res_valid_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef PP_COUNT_CHECK_EN
  logic [8:0] count, count_nxt;
  logic       err_nxt;

  // Saturating beat count; the verdict is latched with the last beat and cleared on result take.
  always_comb begin
    count_nxt = count;
    err_nxt   = err;
    if (pp_hs) begin
      count_nxt = (count == 9'h1FF) ? count : count + 9'd1;
      if (bus.pp_last) err_nxt = ((10'(count) + 10'd1) != 10'(NPP));
    end
    if (res_hs) begin
      count_nxt = '0;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      err   <= err_nxt;
    end
  end
`else
  assign err = 1'b0;

  // NPP only sizes the count check, which is compiled out in this build.
  if (NPP == 0) begin : g_npp_unused
  end
`endif
endmodule

// File: tb/tb_gf233_pp_accum_reduce.sv
// Randomized directed bench for gf233_pp_accum_reduce with a polynomial-arithmetic reference model.
module tb_gf233_pp_accum_reduce;
  logic clk = 1'b0;
  logic rst;
  logic busy, err;
  int   checks = 0;
  int   errors = 0;

  logic [479:0] m_acc;
  int           m_n;

  always #5 clk = ~clk;

  gf233_pp_accum_reduce_if bus ();

  gf233_pp_accum_reduce dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  task automatic check(input string tag, input logic [232:0] obs, input logic [232:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] clmul(input logic [14:0] x, input logic [14:0] y);
    logic [28:0] r = '0;
    for (int t = 0; t < 15; t++) if (y[t]) r ^= (29'(x) << t);
    return r;
  endfunction

  // Long-division reduction of an arbitrary polynomial, one high bit at a time.
  function automatic logic [232:0] reduce(input logic [479:0] v);
    logic [479:0] w = v;
    for (int b = 479; b >= 233; b--) begin
      if (w[b]) begin
        w[b]       = 1'b0;
        w[b - 159] = ~w[b - 159];
        w[b - 233] = ~w[b - 233];
      end
    end
    return w[232:0];
  endfunction

  // Shift-and-add field multiplication, independent of digit decomposition.
  function automatic logic [232:0] mulmod(input logic [232:0] a, input logic [232:0] b);
    logic [233:0] r = '0;
    logic [233:0] f = '0;
    f[233] = 1'b1; f[74] = 1'b1; f[0] = 1'b1;
    for (int k = 232; k >= 0; k--) begin
      r = {r[232:0], 1'b0};
      if (r[233]) r ^= f;
      if (b[k]) r[232:0] ^= a;
    end
    return r[232:0];
  endfunction

  function automatic logic exp_err();
`ifdef PP_COUNT_CHECK_EN
    return (m_n != 256);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [232:0] rand233();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
    return t[232:0];
  endfunction

  // One accepted beat, optionally preceded by an idle cycle carrying a stray pp_last.
  task automatic beat(input logic [28:0] d, input logic [3:0] i, input logic [3:0] j, input logic last);
    int s;
    if ($urandom_range(0, 3) == 0) begin
      bus.pp_valid = 1'b0;
      bus.pp_last  = 1'b1;
      bus.pp_data  = 29'($urandom);
      @(posedge clk); #1;
    end
    bus.pp_valid = 1'b1;
    bus.pp_data  = d;
    bus.pp_i     = i;
    bus.pp_j     = j;
    bus.pp_last  = last;
    @(posedge clk); #1;
    bus.pp_valid = 1'b0;
    bus.pp_last  = 1'b0;
    s = 15 * (int'(i) + int'(j));
    m_acc ^= (480'(d) << s);
    m_n++;
  endtask

  // Called right after the last beat's edge; checks fixed latency, hold under backpressure and the take.
  task automatic finish_op(input string tag, input logic [232:0] exp, input int hold);
    @(posedge clk); #1;
    check($sformatf("%s.valid_n1", tag), bus.res_valid, 1'b0);
    @(posedge clk); #1;
    check($sformatf("%s.valid_n2", tag), bus.res_valid, 1'b1);
    check($sformatf("%s.data", tag), bus.res_data, exp);
    check($sformatf("%s.err", tag), err, exp_err());
    check($sformatf("%s.ppready_out", tag), bus.pp_ready, 1'b0);
    check($sformatf("%s.busy_out", tag), busy, 1'b1);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check($sformatf("%s.hold_valid", tag), bus.res_valid, 1'b1);
      check($sformatf("%s.hold_data", tag), bus.res_data, exp);
      check($sformatf("%s.hold_ppready", tag), bus.pp_ready, 1'b0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check($sformatf("%s.post_valid", tag), bus.res_valid, 1'b0);
    check($sformatf("%s.post_ppready", tag), bus.pp_ready, 1'b1);
    check($sformatf("%s.post_busy", tag), busy, 1'b0);
    check($sformatf("%s.post_err", tag), err, 1'b0);
    check($sformatf("%s.post_data", tag), bus.res_data, exp);
    m_acc = '0;
    m_n   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.ppready", tag), bus.pp_ready, 1'b1);
    check($sformatf("%s.valid", tag), bus.res_valid, 1'b0);
    check($sformatf("%s.data", tag), bus.res_data, '0);
    check($sformatf("%s.busy", tag), busy, 1'b0);
    check($sformatf("%s.err", tag), err, 1'b0);
  endtask

  initial begin
    logic [232:0] e;
    logic [239:0] ad, bd;
    logic [232:0] a, b;
    int           ord [256];
    int           n, p, r, tmp;

    rst = 1'b1;
    bus.pp_valid = 1'b0; bus.pp_data = '0; bus.pp_i = '0; bus.pp_j = '0;
    bus.pp_last = 1'b0; bus.res_ready = 1'b0;
    m_acc = '0; m_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Reset mid-ACC after three beats, then a single-beat operation.
    for (int k = 0; k < 3; k++) beat(29'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_acc");
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0; m_n = 0;
    beat(29'h1, 4'd0, 4'd0, 1'b1);
    finish_op("rst_single", 233'h1, 0);

    // Reset while folding discards the operation.
    beat(29'($urandom), 4'd3, 4'd9, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_fold");
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0; m_n = 0;

    beat(29'h1, 4'd0, 4'd0, 1'b1);
    finish_op("single", 233'h1, 0);

    beat(29'(1) << 7, 4'd15, 4'd15, 1'b1);
    e = '0; e[224] = 1'b1; e[139] = 1'b1; e[65] = 1'b1;
    finish_op("x457", e, 0);

    beat(29'h0ABCDEF, 4'd1, 4'd2, 1'b0);
    beat(29'h0ABCDEF, 4'd2, 4'd1, 1'b1);
    finish_op("cancel", '0, 0);

    beat(29'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    finish_op("backpressure", reduce(m_acc), 5);

    for (int k = 0; k < 3; k++) beat(29'($urandom), 4'($urandom), 4'($urandom), k == 2);
    finish_op("three_beats", reduce(m_acc), 1);

    for (int k = 0; k < 256; k++) beat(29'h0, 4'(k / 16), 4'(k % 16), k == 255);
    finish_op("zeros256", '0, 0);

    // Full digit-serial products in random beat order against field multiplication.
    for (int t = 0; t < 3; t++) begin
      a = rand233(); b = rand233();
      ad = 240'(a); bd = 240'(b);
      for (int k = 0; k < 256; k++) ord[k] = k;
      for (int k = 255; k > 0; k--) begin
        r = $urandom_range(0, k);
        tmp = ord[k]; ord[k] = ord[r]; ord[r] = tmp;
      end
      for (int k = 0; k < 256; k++) begin
        p = ord[k];
        beat(clmul(ad[15*(p/16) +: 15], bd[15*(p%16) +: 15]), 4'(p / 16), 4'(p % 16), k == 255);
      end
      finish_op($sformatf("mul%0d", t), mulmod(a, b), t);
    end

    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) beat(29'($urandom), 4'($urandom), 4'($urandom), k == n - 1);
      finish_op($sformatf("stream%0d", t), reduce(m_acc), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
